histogram_roi_extractor: RTL
============================

Name: histogram_roi_extractor

Overview:
- Sits directly downstream of the x/y histogram accumulator. Consumes its read-out streams: one 8-bit bin per valid beat per axis, bins in ascending index order starting at 0.
- Per axis, extracts the peak bin (index and count) and the first and last bins whose count is at or above a programmable threshold. Together these give a region-of-interest bounding box for the tracking logic.
- Results are latched and held until the next capture.

Parameters:
- IMAGE_WIDTH, 240, number of x bins (max 256)
- IMAGE_HEIGHT, 180, number of y bins (max 256)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; arms a new capture
- threshold  in  8  bin qualification level, sampled on start
- xHistIn  in  8  x bin count
- xValid  in  1  xHistIn valid
- yHistIn  in  8  y bin count
- yValid  in  1  yHistIn valid
- xPeakIdx  out  8  index of largest x bin
- xPeakVal  out  8  count of largest x bin
- yPeakIdx  out  8  index of largest y bin
- yPeakVal  out  8  count of largest y bin
- xMin  out  8  first qualifying x index
- xMax  out  8  last qualifying x index
- yMin  out  8  first qualifying y index
- yMax  out  8  last qualifying y index
- roiFound  out  1  at least one qualifying bin on both axes
- resultValid  out  1  one-cycle pulse, results updated
- busy  out  1  capture in progress

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk.
- Reset values: all outputs 0; state IDLE. Reset mid-capture aborts and clears everything.
- States:
  - IDLE: start -> ACCUM. On entry to ACCUM, clear per-axis accumulators, index counters and complete flags; latch threshold; busy=1 from the next cycle.
  - ACCUM: per axis independently, each valid beat processes bin = current index counter, then the counter increments.
  - Axis complete when IMAGE_WIDTH (or IMAGE_HEIGHT) beats have been received, or when valid is low in a cycle after at least one beat was received.
  - Beats on a completed axis are ignored.
  - Both axes complete -> FINISH.
  - FINISH: one cycle. Copy accumulators to outputs; resultValid=1; busy=0 next cycle; -> IDLE.
- Peak: a bin replaces the current peak only when strictly greater, so ties keep the lowest index. An all-zero histogram gives idx 0, val 0.
- Qualification is bin >= threshold (8-bit unsigned).
  - Min = index of the first qualifying bin; Max = index of the last qualifying bin.
  - No qualifying bin on an axis: Min=Max=0 for that axis and roiFound=0.
- Valid beats while IDLE or FINISH are ignored. start while not IDLE is ignored.
- start and valid in the same cycle: that beat is ignored; capture begins the next cycle.
- Outputs hold until the next FINISH. A capture aborted by reset never updates outputs.
- Latency: resultValid is asserted 2 cycles after the last axis completes (1 cycle to detect, 1 cycle in FINISH).

Optional Feature:
- Macro: HISTOGRAM_ROI_MOMENT_EN.
- Defined:
  - Adds outputs xMass [15:0], yMass [15:0]: sum of bin counts per axis.
  - Adds outputs xMoment [23:0], yMoment [23:0]: sum of index*count per axis.
  - Accumulated in ACCUM, latched in FINISH, reset to 0. Widths cover the worst case 255 counts in every bin with no overflow.
  - Host divides Moment by Mass to obtain the centroid.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Basic ROI: threshold=5; x stream of 240 beats with bins 10..20 =7, bin 15 =9, others 0; y stream of 180 beats with bins 30..40 =6.
  -> xPeakIdx=15, xPeakVal=9, xMin=10, xMax=20; yPeakIdx=30, yPeakVal=6, yMin=30, yMax=40; roiFound=1; one resultValid pulse.
- Ties: x bins 3 and 100 both =50, all others lower.
  -> xPeakIdx=3.
- Empty histogram: all bins 0, threshold=1.
  -> roiFound=0, all Min/Max=0, xPeakIdx=0, xPeakVal=0.
- Early termination: x stream of 100 beats then xValid low; y stream of 180 beats.
  -> capture completes; bins beyond 99 are treated as absent. Extra valid beats after completion do not alter results.
- Reset mid-capture, after 50 beats.
  -> outputs 0, busy=0, no resultValid. A subsequent full capture produces correct results.
- Threshold=0 (with HISTOGRAM_ROI_MOMENT_EN defined): every x bin=1.
  -> xMin=0, xMax=239, xMass=240, xMoment=28680.

Source files
------------

// File: rtl/histogram_roi_extractor.sv
// Peak and threshold bounding box per axis, taken from the x/y histogram read-out streams.
// Optional centroid moments when HISTOGRAM_ROI_MOMENT_EN is defined.

module histogram_roi_axis #(
  parameter int N = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic        vld,
  input  logic [7:0]  bin,
  input  logic [7:0]  thr,
  output logic        done,
  output logic [7:0]  peak_idx,
  output logic [7:0]  peak_val,
  output logic [7:0]  min_idx,
  output logic [7:0]  max_idx,
  output logic        found
`ifdef HISTOGRAM_ROI_MOMENT_EN
  ,
  output logic [15:0] mass,
  output logic [23:0] moment
`endif
);

  logic [8:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [7:0]  peak_idx_q, peak_idx_d;
  logic [7:0]  peak_val_q, peak_val_d;
  logic [7:0]  min_q, min_d;
  logic [7:0]  max_q, max_d;
  logic        found_q, found_d;
`ifdef HISTOGRAM_ROI_MOMENT_EN
  logic [15:0] mass_q, mass_d;
  logic [23:0] moment_q, moment_d;
`endif

  always_comb begin
    cnt_d      = cnt_q;
    done_d     = done_q;
    peak_idx_d = peak_idx_q;
    peak_val_d = peak_val_q;
    min_d      = min_q;
    max_d      = max_q;
    found_d    = found_q;
`ifdef HISTOGRAM_ROI_MOMENT_EN
    mass_d     = mass_q;
    moment_d   = moment_q;
`endif
    if (clear) begin
      cnt_d      = '0;
      done_d     = 1'b0;
      peak_idx_d = '0;
      peak_val_d = '0;
      min_d      = '0;
      max_d      = '0;
      found_d    = 1'b0;
`ifdef HISTOGRAM_ROI_MOMENT_EN
      mass_d     = '0;
      moment_d   = '0;
`endif
    end else if (en && !done_q) begin
      if (vld) begin
        // Strictly greater keeps the lowest index on ties.
        if (bin > peak_val_q) begin
          peak_val_d = bin;
          peak_idx_d = cnt_q[7:0];
        end
        if (bin >= thr) begin
          if (!found_q) min_d = cnt_q[7:0];
          max_d   = cnt_q[7:0];
          found_d = 1'b1;
        end
`ifdef HISTOGRAM_ROI_MOMENT_EN
        mass_d   = mass_q + 16'(bin);
        moment_d = moment_q + 24'(cnt_q[7:0]) * 24'(bin);
`endif
        cnt_d = cnt_q + 9'd1;
        if (cnt_q == 9'(N - 1)) done_d = 1'b1;
      end else if (cnt_q != 9'd0) begin
        // A gap after the stream has started marks a short histogram.
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      done_q     <= 1'b0;
      peak_idx_q <= '0;
      peak_val_q <= '0;
      min_q      <= '0;
      max_q      <= '0;
      found_q    <= 1'b0;
`ifdef HISTOGRAM_ROI_MOMENT_EN
      mass_q     <= '0;
      moment_q   <= '0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      peak_idx_q <= peak_idx_d;
      peak_val_q <= peak_val_d;
      min_q      <= min_d;
      max_q      <= max_d;
      found_q    <= found_d;
`ifdef HISTOGRAM_ROI_MOMENT_EN
      mass_q     <= mass_d;
      moment_q   <= moment_d;
`endif
    end
  end

  assign done     = done_q;
  assign peak_idx = peak_idx_q;
  assign peak_val = peak_val_q;
  assign min_idx  = min_q;
  assign max_idx  = max_q;
  assign found    = found_q;
`ifdef HISTOGRAM_ROI_MOMENT_EN
  assign mass     = mass_q;
  assign moment   = moment_q;
`endif

endmodule

module histogram_roi_extractor #(
  parameter int IMAGE_WIDTH  = 240,
  parameter int IMAGE_HEIGHT = 180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  threshold,
  input  logic [7:0]  xHistIn,
  input  logic        xValid,
  input  logic [7:0]  yHistIn,
  input  logic        yValid,
  output logic [7:0]  xPeakIdx,
  output logic [7:0]  xPeakVal,
  output logic [7:0]  yPeakIdx,
  output logic [7:0]  yPeakVal,
  output logic [7:0]  xMin,
  output logic [7:0]  xMax,
  output logic [7:0]  yMin,
  output logic [7:0]  yMax,
  output logic        roiFound,
  output logic        resultValid,
  output logic        busy
`ifdef HISTOGRAM_ROI_MOMENT_EN
  ,
  output logic [15:0] xMass,
  output logic [15:0] yMass,
  output logic [23:0] xMoment,
  output logic [23:0] yMoment
`endif
);

  typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;
  state_t state_q, state_d;

  logic       clear, accum_en, capture;
  logic [7:0] thr_q, thr_d;
  logic       x_done, y_done, x_found, y_found;
  logic [7:0] x_pidx, x_pval, x_min, x_max, y_pidx, y_pval, y_min, y_max;

  // Held results: {xPeakIdx, xPeakVal, xMin, xMax, yPeakIdx, yPeakVal, yMin, yMax}.
  logic [63:0] res_q, res_d;
  logic        roi_q, roi_d;
  logic        rv_q, rv_d;
`ifdef HISTOGRAM_ROI_MOMENT_EN
  logic [15:0] x_mass, y_mass;
  logic [23:0] x_mom, y_mom;
  logic [79:0] mom_q, mom_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (x_done && y_done) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clear    = (state_q == IDLE) && start;
    accum_en = (state_q == ACCUM);
    capture  = (state_q == FINISH);
    busy     = (state_q != IDLE);
  end

  histogram_roi_axis #(.N(IMAGE_WIDTH)) u_x (
    .clk(clk), .reset(reset), .clear(clear), .en(accum_en),
    .vld(xValid), .bin(xHistIn), .thr(thr_q), .done(x_done),
    .peak_idx(x_pidx), .peak_val(x_pval), .min_idx(x_min), .max_idx(x_max),
    .found(x_found)
`ifdef HISTOGRAM_ROI_MOMENT_EN
    , .mass(x_mass), .moment(x_mom)
`endif
  );

  histogram_roi_axis #(.N(IMAGE_HEIGHT)) u_y (
    .clk(clk), .reset(reset), .clear(clear), .en(accum_en),
    .vld(yValid), .bin(yHistIn), .thr(thr_q), .done(y_done),
    .peak_idx(y_pidx), .peak_val(y_pval), .min_idx(y_min), .max_idx(y_max),
    .found(y_found)
`ifdef HISTOGRAM_ROI_MOMENT_EN
    , .mass(y_mass), .moment(y_mom)
`endif
  );

  always_comb begin
    thr_d = clear ? threshold : thr_q;
    res_d = res_q;
    roi_d = roi_q;
    rv_d  = capture;
`ifdef HISTOGRAM_ROI_MOMENT_EN
    mom_d = mom_q;
`endif
    if (capture) begin
      res_d = {x_pidx, x_pval, x_min, x_max, y_pidx, y_pval, y_min, y_max};
      roi_d = x_found && y_found;
`ifdef HISTOGRAM_ROI_MOMENT_EN
      mom_d = {x_mass, y_mass, x_mom, y_mom};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      thr_q <= '0;
      res_q <= '0;
      roi_q <= 1'b0;
      rv_q  <= 1'b0;
`ifdef HISTOGRAM_ROI_MOMENT_EN
      mom_q <= '0;
`endif
    end else begin
      thr_q <= thr_d;
      res_q <= res_d;
      roi_q <= roi_d;
      rv_q  <= rv_d;
`ifdef HISTOGRAM_ROI_MOMENT_EN
      mom_q <= mom_d;
`endif
    end
  end

  assign {xPeakIdx, xPeakVal, xMin, xMax, yPeakIdx, yPeakVal, yMin, yMax} = res_q;
  assign roiFound    = roi_q;
  assign resultValid = rv_q;
`ifdef HISTOGRAM_ROI_MOMENT_EN
  assign {xMass, yMass, xMoment, yMoment} = mom_q;
`endif

endmodule
